// File: rtl/mc_control_fsm_if.sv
// Control/datapath bundle for the multi-cycle sequencer: instruction fields and
// memory handshake in, datapath enables/selects and status out.
interface mc_control_fsm_if #(
    parameter int CNT_W = 32
);
    logic             run;
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic             mem_ready;
    logic             pc_write;
    logic [1:0]       pc_src;
    logic             iord;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             reg_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic             ext_zero;
    logic [3:0]       alu_ctrl;
    logic [3:0]       state_o;
    logic             illegal;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  run, opcode, funct, zero, mem_ready,
        output pc_write, pc_src, iord, mem_read, mem_write, ir_write, reg_write,
               reg_dst, mem_to_reg, alu_src_a, alu_src_b, ext_zero, alu_ctrl,
               state_o, illegal, instr_count
    );

    modport slave (
        output run, opcode, funct, zero, mem_ready,
        input  pc_write, pc_src, iord, mem_read, mem_write, ir_write, reg_write,
               reg_dst, mem_to_reg, alu_src_a, alu_src_b, ext_zero, alu_ctrl,
               state_o, illegal, instr_count
    );
endinterface

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS-subset control sequencer: fetch/decode/execute/memory/writeback
// with a variable-latency memory handshake, retire counter and illegal-opcode trap.
module mc_control_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    mc_control_fsm_if.master bus
);
    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        MEM_ADDR = 4'd3,
        MEM_RD   = 4'd4,
        WB_MEM   = 4'd5,
        MEM_WR   = 4'd6,
        EXEC_R   = 4'd7,
        WB_R     = 4'd8,
        EXEC_I   = 4'd9,
        WB_I     = 4'd10,
        BRANCH   = 4'd11,
        JUMP     = 4'd12,
        TRAP     = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    state_t           state, next_state;
    logic             retire;
    logic             r_legal;
    logic [3:0]       r_ctrl;
    logic [3:0]       i_ctrl;
    logic             i_zext;
    logic             fetch_q, branch_q, bne_q, jump_q;
    logic [1:0]       pc_src_q, alu_src_b_q;
    logic             iord_q, mem_read_q, mem_write_q, reg_write_q, reg_dst_q;
    logic             mem_to_reg_q, alu_src_a_q, ext_zero_q, illegal_q;
    logic [3:0]       alu_ctrl_q;
    logic [CNT_W-1:0] count_q;

    always_comb begin
        r_legal = 1'b1;
        r_ctrl  = ALU_ADD;
        case (bus.funct)
            6'b100000: r_ctrl = ALU_ADD;
            6'b100010: r_ctrl = ALU_SUB;
            6'b100100: r_ctrl = ALU_AND;
            6'b100101: r_ctrl = ALU_OR;
            6'b101010: r_ctrl = ALU_SLT;
            6'b100111: r_ctrl = ALU_NOR;
            default:   r_legal = 1'b0;
        endcase
    end

    always_comb begin
        i_ctrl = ALU_ADD;
        i_zext = 1'b0;
        case (bus.opcode)
            OP_ANDI: begin i_ctrl = ALU_AND; i_zext = 1'b1; end
            OP_ORI:  begin i_ctrl = ALU_OR;  i_zext = 1'b1; end
            OP_SLTI: i_ctrl = ALU_SLT;
            default: i_ctrl = ALU_ADD;
        endcase
    end

    // Retiring states share one exit: back to FETCH if run is high, else park in IDLE.
    always_comb begin
        next_state = state;
        retire     = 1'b0;
        case (state)
            IDLE:     if (bus.run) next_state = FETCH;
            FETCH:    if (bus.mem_ready) next_state = DECODE;
            DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:                         next_state = r_legal ? EXEC_R : TRAP;
                    OP_LW, OP_SW:                     next_state = MEM_ADDR;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: next_state = EXEC_I;
                    OP_BEQ, OP_BNE:                   next_state = BRANCH;
                    OP_J:                             next_state = JUMP;
                    default:                          next_state = TRAP;
                endcase
            end
            MEM_ADDR: next_state = (bus.opcode == OP_SW) ? MEM_WR : MEM_RD;
            MEM_RD:   if (bus.mem_ready) next_state = WB_MEM;
            MEM_WR:   retire = bus.mem_ready;
            EXEC_R:   next_state = WB_R;
            EXEC_I:   next_state = WB_I;
            WB_MEM, WB_R, WB_I, BRANCH, JUMP: retire = 1'b1;
            TRAP:     next_state = TRAP;
            default:  next_state = IDLE;
        endcase
        if (retire) next_state = bus.run ? FETCH : IDLE;
    end

    // Outputs are registered from the upcoming state; only the mem_ready/zero
    // qualified enables are combined after the register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            count_q      <= '0;
            fetch_q      <= 1'b0;
            branch_q     <= 1'b0;
            bne_q        <= 1'b0;
            jump_q       <= 1'b0;
            pc_src_q     <= 2'b00;
            alu_src_b_q  <= 2'b00;
            iord_q       <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            reg_write_q  <= 1'b0;
            reg_dst_q    <= 1'b0;
            mem_to_reg_q <= 1'b0;
            alu_src_a_q  <= 1'b0;
            ext_zero_q   <= 1'b0;
            illegal_q    <= 1'b0;
            alu_ctrl_q   <= 4'b0000;
        end else begin
            state <= next_state;
            if (retire) count_q <= count_q + 1'b1;

            fetch_q      <= 1'b0;
            branch_q     <= 1'b0;
            bne_q        <= 1'b0;
            jump_q       <= 1'b0;
            pc_src_q     <= 2'b00;
            alu_src_b_q  <= 2'b00;
            iord_q       <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            reg_write_q  <= 1'b0;
            reg_dst_q    <= 1'b0;
            mem_to_reg_q <= 1'b0;
            alu_src_a_q  <= 1'b0;
            ext_zero_q   <= 1'b0;
            illegal_q    <= 1'b0;
            alu_ctrl_q   <= 4'b0000;

            case (next_state)
                FETCH: begin
                    fetch_q     <= 1'b1;
                    mem_read_q  <= 1'b1;
                    alu_src_b_q <= 2'b01;
                    alu_ctrl_q  <= ALU_ADD;
                end
                DECODE: begin
                    alu_src_b_q <= 2'b11;
                    alu_ctrl_q  <= ALU_ADD;
                end
                MEM_ADDR: begin
                    alu_src_a_q <= 1'b1;
                    alu_src_b_q <= 2'b10;
                    alu_ctrl_q  <= ALU_ADD;
                end
                MEM_RD: begin
                    mem_read_q <= 1'b1;
                    iord_q     <= 1'b1;
                end
                MEM_WR: begin
                    mem_write_q <= 1'b1;
                    iord_q      <= 1'b1;
                end
                WB_MEM: begin
                    reg_write_q  <= 1'b1;
                    mem_to_reg_q <= 1'b1;
                end
                EXEC_R: begin
                    alu_src_a_q <= 1'b1;
                    alu_ctrl_q  <= r_ctrl;
                end
                WB_R: begin
                    reg_write_q <= 1'b1;
                    reg_dst_q   <= 1'b1;
                end
                EXEC_I: begin
                    alu_src_a_q <= 1'b1;
                    alu_src_b_q <= 2'b10;
                    alu_ctrl_q  <= i_ctrl;
                    ext_zero_q  <= i_zext;
                end
                WB_I:   reg_write_q <= 1'b1;
                BRANCH: begin
                    branch_q    <= 1'b1;
                    bne_q       <= (bus.opcode == OP_BNE);
                    alu_src_a_q <= 1'b1;
                    alu_ctrl_q  <= ALU_SUB;
                    pc_src_q    <= 2'b01;
                end
                JUMP: begin
                    jump_q   <= 1'b1;
                    pc_src_q <= 2'b10;
                end
                TRAP:    illegal_q <= 1'b1;
                default: illegal_q <= 1'b0;
            endcase
        end
    end

    assign bus.pc_write    = jump_q | (fetch_q & bus.mem_ready) | (branch_q & (bne_q ^ bus.zero));
    assign bus.ir_write    = fetch_q & bus.mem_ready;
    assign bus.pc_src      = pc_src_q;
    assign bus.iord        = iord_q;
    assign bus.mem_read    = mem_read_q;
    assign bus.mem_write   = mem_write_q;
    assign bus.reg_write   = reg_write_q;
    assign bus.reg_dst     = reg_dst_q;
    assign bus.mem_to_reg  = mem_to_reg_q;
    assign bus.alu_src_a   = alu_src_a_q;
    assign bus.alu_src_b   = alu_src_b_q;
    assign bus.ext_zero    = ext_zero_q;
    assign bus.alu_ctrl    = alu_ctrl_q;
    assign bus.state_o     = state;
    assign bus.illegal     = illegal_q;
    assign bus.instr_count = count_q;
endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomized scoreboard bench for mc_control_fsm: each instruction is expanded into
// its expected per-cycle phase list, and a monitor compares every cycle at negedge.
module tb_mc_control_fsm;
    localparam int CNT_W   = 4;
    localparam int CNT_MOD = 1 << CNT_W;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;

    typedef struct packed {
        logic [3:0]       st;
        logic             pc_write;
        logic [1:0]       pc_src;
        logic             iord;
        logic             mem_read;
        logic             mem_write;
        logic             ir_write;
        logic             reg_write;
        logic             reg_dst;
        logic             mem_to_reg;
        logic             alu_src_a;
        logic [1:0]       alu_src_b;
        logic             ext_zero;
        logic [3:0]       alu_ctrl;
        logic             illegal;
        logic [CNT_W-1:0] count;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    mc_control_fsm_if #(.CNT_W(CNT_W)) bus ();
    mc_control_fsm #(.CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [5:0] r_fn   [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};
    logic [3:0] r_ctrl [6] = '{4'b0010,   4'b0110,   4'b0000,   4'b0001,   4'b0111,   4'b1100};

    obs_t       exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         mcount   = 0;
    bit         model_idle = 1'b1;
    logic [5:0] op_cur = '0;
    logic [5:0] fn_cur = '0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    function automatic int r_index(input logic [5:0] fn);
        for (int i = 0; i < 6; i++) if (r_fn[i] == fn) return i;
        return -1;
    endfunction

    // Expected observation for one cycle spent in phase st, straight from the output table.
    function automatic obs_t mk(input int st, input logic z, input logic rdy);
        obs_t e;
        int   ri;
        e       = '0;
        e.st    = 4'(st);
        e.count = CNT_W'(mcount);
        case (st)
            1:  begin e.mem_read = 1; e.alu_src_b = 2'b01; e.alu_ctrl = 4'b0010; e.ir_write = rdy; e.pc_write = rdy; end
            2:  begin e.alu_src_b = 2'b11; e.alu_ctrl = 4'b0010; end
            3:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_ctrl = 4'b0010; end
            4:  begin e.mem_read = 1; e.iord = 1; end
            5:  begin e.reg_write = 1; e.mem_to_reg = 1; end
            6:  begin e.mem_write = 1; e.iord = 1; end
            7:  begin ri = r_index(fn_cur); e.alu_src_a = 1; e.alu_ctrl = (ri >= 0) ? r_ctrl[ri] : 4'b0000; end
            8:  begin e.reg_write = 1; e.reg_dst = 1; end
            9:  begin
                    e.alu_src_a = 1; e.alu_src_b = 2'b10;
                    e.alu_ctrl  = (op_cur == OP_ANDI) ? 4'b0000 : (op_cur == OP_ORI) ? 4'b0001 :
                                  (op_cur == OP_SLTI) ? 4'b0111 : 4'b0010;
                    e.ext_zero  = (op_cur == OP_ANDI) || (op_cur == OP_ORI);
                end
            10: e.reg_write = 1;
            11: begin e.alu_src_a = 1; e.alu_ctrl = 4'b0110; e.pc_src = 2'b01; e.pc_write = (op_cur == OP_BEQ) ? z : !z; end
            12: begin e.pc_src = 2'b10; e.pc_write = 1; end
            15: e.illegal = 1;
            default: e.illegal = 0;
        endcase
        return e;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic applyStimulus(input logic r, input logic rdy, input logic z, input int st);
        bus.run       = r;
        bus.mem_ready = rdy;
        bus.zero      = z;
        bus.opcode    = op_cur;
        bus.funct     = fn_cur;
        exp_q.push_back(mk(st, z, rdy));
        @(posedge clk);
        #1;
    endtask

    // One instruction: expand into its phase list; run only matters in IDLE and the retire cycle.
    task automatic runInstr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                            input int fw, input int mw, input logic run_ret, input bit abort_memwr);
        op_cur = op;
        fn_cur = fn;
        if (model_idle) begin
            repeat ($urandom_range(0, 2)) applyStimulus(1'b0, rb(), rb(), 0);
            applyStimulus(1'b1, rb(), rb(), 0);
        end
        model_idle = 1'b0;
        repeat (fw) applyStimulus(rb(), 1'b0, rb(), 1);
        applyStimulus(rb(), 1'b1, rb(), 1);
        applyStimulus(rb(), rb(), rb(), 2);
        if (op == 6'b000000 && r_index(fn) >= 0) begin
            applyStimulus(rb(), rb(), rb(), 7);
            applyStimulus(run_ret, rb(), rb(), 8);
        end else if (op == OP_LW) begin
            applyStimulus(rb(), rb(), rb(), 3);
            repeat (mw) applyStimulus(rb(), 1'b0, rb(), 4);
            applyStimulus(rb(), 1'b1, rb(), 4);
            applyStimulus(run_ret, rb(), rb(), 5);
        end else if (op == OP_SW) begin
            applyStimulus(rb(), rb(), rb(), 3);
            repeat (mw) applyStimulus(rb(), 1'b0, rb(), 6);
            if (abort_memwr) return;
            applyStimulus(run_ret, 1'b1, rb(), 6);
        end else if (op == OP_ADDI || op == OP_ANDI || op == OP_ORI || op == OP_SLTI) begin
            applyStimulus(rb(), rb(), rb(), 9);
            applyStimulus(run_ret, rb(), rb(), 10);
        end else if (op == OP_BEQ || op == OP_BNE) begin
            applyStimulus(run_ret, rb(), z, 11);
        end else if (op == OP_J) begin
            applyStimulus(run_ret, rb(), rb(), 12);
        end else begin
            repeat (20) applyStimulus(rb(), rb(), rb(), 15);
            return;
        end
        mcount     = (mcount + 1) % CNT_MOD;
        model_idle = !run_ret;
    endtask

    task automatic randInstr(input bit allow_stop);
        logic [5:0] op, fn;
        int k;
        k  = $urandom_range(0, 13);
        fn = 6'($urandom);
        case (k)
            0, 1, 2, 3, 4, 5: begin op = 6'b000000; fn = r_fn[k]; end
            6:  op = OP_LW;
            7:  op = OP_SW;
            8:  op = OP_ADDI;
            9:  op = OP_ANDI;
            10: op = OP_ORI;
            11: op = OP_SLTI;
            12: op = rb() ? OP_BEQ : OP_BNE;
            default: op = OP_J;
        endcase
        runInstr(op, fn, rb(), $urandom_range(0, 2), $urandom_range(0, 3),
                 allow_stop ? ($urandom_range(0, 3) != 0) : 1'b1, 1'b0);
    endtask

    task automatic doReset();
        @(negedge clk);
        #1;
        bus.run = 1'b0;
        rst_n   = 1'b0;
        #1;
        checkOutput("reset_state",     64'(bus.state_o),     64'd0);
        checkOutput("reset_count",     64'(bus.instr_count), 64'd0);
        checkOutput("reset_mem_rw",    64'({bus.mem_read, bus.mem_write}), 64'd0);
        checkOutput("reset_pc_ir_reg", 64'({bus.pc_write, bus.ir_write, bus.reg_write, bus.illegal}), 64'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mcount     = 0;
        model_idle = 1'b1;
    endtask

    initial begin
        obs_t e, act;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                act = '{bus.state_o, bus.pc_write, bus.pc_src, bus.iord, bus.mem_read, bus.mem_write,
                        bus.ir_write, bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.alu_src_a,
                        bus.alu_src_b, bus.ext_zero, bus.alu_ctrl, bus.illegal, bus.instr_count};
                checkOutput($sformatf("cycle_phase%0d_op%b", e.st, op_cur), 64'(act), 64'(e));
            end
        end
    end

    initial begin
        bus.run = 1'b0; bus.mem_ready = 1'b0; bus.zero = 1'b0;
        bus.opcode = '0; bus.funct = '0;
        #2;
        doReset();

        runInstr(6'b000000, 6'b100000, 1'b0, 0, 0, 1'b1, 1'b0);
        checkOutput("count_after_add", 64'(bus.instr_count), 64'd1);
        runInstr(OP_LW,  6'd0, 1'b0, 0, 3, 1'b1, 1'b0);
        runInstr(OP_BEQ, 6'd0, 1'b1, 0, 0, 1'b1, 1'b0);
        runInstr(OP_BNE, 6'd0, 1'b1, 0, 0, 1'b1, 1'b0);
        checkOutput("count_after_branches", 64'(bus.instr_count), 64'd4);
        runInstr(OP_SW,   6'd0, 1'b0, 1, 2, 1'b1, 1'b0);
        runInstr(OP_J,    6'd0, 1'b0, 2, 0, 1'b1, 1'b0);
        runInstr(OP_ADDI, 6'd0, 1'b0, 0, 0, 1'b1, 1'b0);
        runInstr(OP_ANDI, 6'd0, 1'b0, 0, 0, 1'b1, 1'b0);
        runInstr(OP_SLTI, 6'd0, 1'b0, 0, 0, 1'b1, 1'b0);
        for (int i = 1; i < 6; i++) runInstr(6'b000000, r_fn[i], 1'b0, 0, 0, 1'b1, 1'b0);
        runInstr(OP_ORI, 6'd0, 1'b0, 0, 0, 1'b0, 1'b0);
        applyStimulus(1'b0, rb(), rb(), 0);

        for (int i = 0; i < 150; i++) randInstr(1'b1);

        doReset();
        for (int i = 0; i < 15; i++) randInstr(1'b0);
        checkOutput("wrap_at_15", 64'(bus.instr_count), 64'd15);
        randInstr(1'b0);
        checkOutput("wrap_to_0", 64'(bus.instr_count), 64'd0);

        runInstr(OP_SW, 6'd0, 1'b0, 0, 2, 1'b1, 1'b1);
        checkOutput("memwr_before_reset", 64'(bus.mem_write), 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("memwr_drop_on_reset", 64'(bus.mem_write),   64'd0);
        checkOutput("state_on_reset",      64'(bus.state_o),     64'd0);
        checkOutput("count_on_reset",      64'(bus.instr_count), 64'd0);
        @(negedge clk);
        #1;
        rst_n   = 1'b1;
        bus.run = 1'b0;
        @(posedge clk);
        #1;
        mcount     = 0;
        model_idle = 1'b1;

        runInstr(6'b000010, 6'd0, 1'b0, 0, 0, 1'b1, 1'b0);
        runInstr(6'b111111, 6'd0, 1'b0, 0, 0, 1'b1, 1'b0);
        checkOutput("trap_illegal_op", 64'(bus.illegal), 64'd1);
        doReset();
        runInstr(6'b000000, 6'b000000, 1'b0, 1, 0, 1'b1, 1'b0);
        checkOutput("trap_illegal_funct", 64'(bus.illegal), 64'd1);
        doReset();

        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multi-cycle control sequencer for the team's MIPS-subset datapath: instruction memory, data RAM, register file, ALU and PC.
- Takes the opcode/funct of the fetched instruction and walks it through fetch, decode, execute, memory and writeback states.
- Drives every datapath enable and mux select, and handshakes with a variable-latency memory port.
- Counts retired instructions and traps on illegal encodings.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock, all state updates on posedge
rst_n  in  1  asynchronous active-low reset
run  in  1  allow fetching; sampled only at instruction boundary
opcode  in  6  instr[31:26] from instruction register
funct  in  6  instr[5:0] from instruction register
zero  in  1  ALU zero flag, combinational, same cycle
mem_ready  in  1  memory completes the current read/write this cycle
pc_write  out  1  PC load enable
pc_src  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target
iord  out  1  memory address select: 0 PC, 1 ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  instruction register load
reg_write  out  1  register file write enable
reg_dst  out  1  0 rt, 1 rd
mem_to_reg  out  1  0 ALUOut, 1 memory data
alu_src_a  out  1  0 PC, 1 rs
alu_src_b  out  2  00 rt, 01 const 4, 10 extended imm, 11 extended imm<<2
ext_zero  out  1  1 zero-extend imm (andi/ori), 0 sign-extend
alu_ctrl  out  4  0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt, 1100 nor
state_o  out  4  current state code (debug)
illegal  out  1  in TRAP
instr_count  out  CNT_W  retired instruction count

Behaviour:
- States (code):
  - IDLE 0, FETCH 1, DECODE 2, MEM_ADDR 3, MEM_RD 4, WB_MEM 5, MEM_WR 6
  - EXEC_R 7, WB_R 8, EXEC_I 9, WB_I 10, BRANCH 11, JUMP 12, TRAP 15
- Reset (async, rst_n=0):
  - State goes to IDLE immediately, even mid-instruction.
  - instr_count=0; all outputs 0, including mem_read/mem_write, which drop without waiting for mem_ready.
- Outputs are Moore decodes of the state register. Exceptions: alu_ctrl/ext_zero in EXEC_R/EXEC_I use opcode/funct; pc_write in BRANCH uses zero. Unlisted outputs are 0.
- IDLE: go to FETCH when run=1.
- FETCH:
  - mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, add.
  - ir_write=pc_write=mem_ready.
  - Stay while mem_ready=0; go to DECODE on mem_ready=1.
- DECODE:
  - alu_src_a=0, alu_src_b=11, add (precomputes branch target).
  - Next state by opcode:
    - 000000 → EXEC_R if funct in {100000,100010,100100,100101,101010,100111}, else TRAP
    - 100011 lw, 101011 sw → MEM_ADDR
    - 001000 addi, 001100 andi, 001101 ori, 001010 slti → EXEC_I
    - 000100 beq, 000101 bne → BRANCH
    - 000010 j → JUMP
    - other → TRAP
- MEM_ADDR: alu_src_a=1, alu_src_b=10, add. Go to MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1, iord=1. Hold until mem_ready, then WB_MEM.
- MEM_WR: mem_write=1, iord=1. Hold until mem_ready; that mem_ready cycle retires.
- WB_MEM: reg_write=1, reg_dst=0, mem_to_reg=1; retire.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_ctrl from funct (add/sub/and/or/slt/nor).
- WB_R: reg_write=1, reg_dst=1; retire.
- EXEC_I: alu_src_a=1, alu_src_b=10. addi→add, slti→slt, andi→and ext_zero=1, ori→or ext_zero=1.
- WB_I: reg_write=1, reg_dst=0; retire.
- BRANCH:
  - alu_src_a=1, alu_src_b=00, sub, pc_src=01.
  - pc_write=(beq&zero)|(bne&~zero).
  - Retire.
- JUMP: pc_src=10, pc_write=1; retire.
- Retire:
  - instr_count increments by 1, wrapping modulo 2^CNT_W.
  - Next state is FETCH if run=1, else IDLE.
  - Deasserting run never aborts an in-flight instruction.
- TRAP: illegal=1, no writes of any kind. Held until reset; run ignored; instr_count not incremented.
- Latency with mem_ready tied to 1:
  - R-type/I-ALU 4 cycles; lw 5; sw 4; beq/bne 3; j 3.
  - Each memory wait cycle adds 1.
- Opcode/funct are assumed stable from DECODE until retire; the IR only loads in FETCH.

Test Plan:
- Reset, run=1, mem_ready=1, R-type add (opcode 000000, funct 100000) → states 1,2,7,8,1. In WB_R: reg_write=1, reg_dst=1. instr_count=1 after 4 cycles.
- lw (100011) with mem_ready low 3 cycles in MEM_RD → stays in state 4 with mem_read=1, iord=1 for 3 cycles. WB_MEM after ready; 8 cycles total; mem_to_reg=1.
- beq with zero=1, then bne with zero=1 → pc_write=1, pc_src=01 in BRANCH for beq. pc_write=0 for bne. Both retire; count +2.
- opcode 111111, then R-type funct 000000 after reset → DECODE→TRAP, illegal=1, no reg_write/mem_write for 20 cycles, count unchanged.
- rst_n low during MEM_WR with mem_ready=0 → mem_write falls same instant; state_o=0; instr_count=0.
- run dropped during EXEC_I of ori → WB_I completes with ext_zero=1 seen in EXEC_I, then IDLE. Preload instr_count=2^CNT_W−1 via forced sequence (CNT_W=4, 15 instructions); the 16th wraps to 0.
